ssds_scan_driver: RTL and testbench
===================================

// Module: ssds_scan_driver
// PURPOSE
//  Time-multiplexed pin driver for the 4-digit seven-segment display.
//  - Consumes the decoded per-digit segment patterns, dot bits and enable from ssds_bus_interface.
//  - Drives the shared segment/dot lines and the per-digit common selects on the board.
//  - Scans one digit at a time, inserting a blanking gap between digits to suppress ghosting.
//  - Samples each digit's pattern once per slot, so bus writes never tear a lit digit.
// PARAMETERS
//  SLOT_CYCLES    50000  clk cycles per digit slot (blank + drive); must be > BLANK_CYCLES
//  BLANK_CYCLES   500    cycles at the start of each slot with all digits off; >= 1
//  SEG_ACTIVE_LOW 1      1: seg_out/dot_out are driven low to light a segment
//  DIG_ACTIVE_LOW 1      1: dig_sel is driven low to select a digit
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  ctrl_en        in   1  display enable
//  ctrl_digit_0   in   7  digit 0 segments, bit0=a .. bit6=g, 1=lit
//  ctrl_digit_1   in   7  digit 1 segments, same bit mapping
//  ctrl_digit_2   in   7  digit 2 segments, same bit mapping
//  ctrl_digit_3   in   7  digit 3 segments, same bit mapping
//  ctrl_dots      in   4  decimal point per digit, bit i = digit i, 1=lit
//  seg_out        out  7  shared segment lines (polarity set by SEG_ACTIVE_LOW)
//  dot_out        out  1  shared decimal-point line (polarity set by SEG_ACTIVE_LOW)
//  dig_sel        out  4  digit commons, bit i = digit i (polarity set by DIG_ACTIVE_LOW)
//  frame_tick     out  1  1-cycle pulse when digit 0 enters DRIVE
// BEHAVIOUR
//  Reset
//   - Synchronous; rst wins over every other event.
//   - Internal state: state=BLANK, idx=0, cnt=0, shadow=0.
//   - Outputs: all inactive (defaults give seg_out=7'h7F, dot_out=1, dig_sel=4'hF); frame_tick=0.
//  Outputs
//   - All outputs are registered; no combinational path from inputs to pins.
//  cnt
//   - Counts 0..SLOT_CYCLES-1 while ctrl_en=1.
//   - Width is $clog2(SLOT_CYCLES).
//  FSM, evaluated each clk while ctrl_en=1
//   - BLANK: cnt++; outputs inactive.
//     - When cnt==BLANK_CYCLES-1: sample ctrl_digit_<idx> and ctrl_dots[idx] into shadow; go to DRIVE.
//     - Next cycle: seg_out/dot_out = shadow and dig_sel = one-hot(idx), both with polarity applied.
//     - frame_tick=1 for that cycle iff idx==0.
//   - DRIVE: cnt++; outputs hold the shadow value; input changes are ignored until the next sample.
//     - When cnt==SLOT_CYCLES-1: cnt<=0; idx<=idx+1 (2-bit wrap, 3->0); go to BLANK.
//     - Outputs are inactive from the next cycle.
//  Slot timing
//   - Each digit is dark for BLANK_CYCLES and lit for SLOT_CYCLES-BLANK_CYCLES.
//   - Frame period = 4*SLOT_CYCLES.
//  ctrl_en=0 (any state)
//   - Next cycle: outputs inactive, state=BLANK, idx=0, cnt=0, frame_tick=0.
//   - When ctrl_en returns to 1, scanning restarts with the digit 0 blank phase.
//  Invariants
//   - At most one dig_sel bit is active in any cycle.
//   - Segments are never active while dig_sel is inactive.
// TESTING
//  SLOT_CYCLES=8, BLANK_CYCLES=2, both polarities active-low.
//  1 rst 1 cycle; release with ctrl_en=0
//    -> seg_out=7'h7F, dot_out=1, dig_sel=4'hF, frame_tick=0 held for 20 cycles.
//  2 ctrl_en=1; digits 0..3 = 7'h3F, 7'h06, 7'h5B, 7'h4F; dots=4'b0100
//    -> per slot: 2 cycles dig_sel=F, then 6 cycles of digit 0 (E / 7'h40, dot 1), digit 1 (D / 7'h79, dot 1),
//       digit 2 (B / 7'h24, dot 0), digit 3 (7 / 7'h30, dot 1).
//    -> frame_tick pulses once every 32 cycles.
//  3 Change ctrl_digit_0 to 7'h7F in DRIVE cycle 3 of slot 0
//    -> seg_out stays 7'h40 until slot end; the next frame shows 7'h00.
//  4 Drop ctrl_en during slot 2 DRIVE; raise it 5 cycles later
//    -> inactive the cycle after the drop; restart with 2 blank cycles, then digit 0.
//  5 Assert rst mid-DRIVE of digit 3
//    -> next cycle all outputs inactive; after release, digit 0 lights after 2 blank cycles.
//  6 Run 1000 random cycles with random inputs and ctrl_en
//    -> assert onehot0 of active dig_sel; assert no active segment without an active dig_sel.

Source files
------------

// File: rtl/ssds_scan_driver_if.sv
// ---------------------------------------------------------------------------
// ssds_scan_driver_if
//   Bundles the seven-segment scan driver's control inputs (from the bus
//   interface block) and its board-pin outputs into one connection.
//
//   Signals
//     ctrl_en        display enable
//     ctrl_digit_0..3 per-digit segment patterns, bit0=a .. bit6=g, 1=lit
//     ctrl_dots      decimal point per digit, bit i = digit i, 1=lit
//     seg_out        shared segment lines (pin polarity)
//     dot_out        shared decimal-point line (pin polarity)
//     dig_sel        digit commons, bit i = digit i (pin polarity)
//     frame_tick     1-cycle pulse when digit 0 starts being driven
//
//   Modports
//     master : the side that supplies ctrl_* and observes the pins
//     slave  : the scan driver itself
// ---------------------------------------------------------------------------
interface ssds_scan_driver_if;
  logic       ctrl_en;
  logic [6:0] ctrl_digit_0;
  logic [6:0] ctrl_digit_1;
  logic [6:0] ctrl_digit_2;
  logic [6:0] ctrl_digit_3;
  logic [3:0] ctrl_dots;
  logic [6:0] seg_out;
  logic       dot_out;
  logic [3:0] dig_sel;
  logic       frame_tick;

  modport master (
    output ctrl_en,
    output ctrl_digit_0,
    output ctrl_digit_1,
    output ctrl_digit_2,
    output ctrl_digit_3,
    output ctrl_dots,
    input  seg_out,
    input  dot_out,
    input  dig_sel,
    input  frame_tick
  );

  modport slave (
    input  ctrl_en,
    input  ctrl_digit_0,
    input  ctrl_digit_1,
    input  ctrl_digit_2,
    input  ctrl_digit_3,
    input  ctrl_dots,
    output seg_out,
    output dot_out,
    output dig_sel,
    output frame_tick
  );
endinterface

// File: rtl/ssds_scan_driver.sv
// ---------------------------------------------------------------------------
// ssds_scan_driver
//   Time-multiplexed pin driver for a 4-digit seven-segment display. Each
//   digit owns a slot of SLOT_CYCLES clocks: the first BLANK_CYCLES are dark
//   (anti-ghosting gap), then the digit pattern captured at the end of the
//   gap is driven for the rest of the slot. Capturing once per slot means a
//   bus write can never change a digit while it is lit.
//
//   Ports
//     clk   in  system clock
//     rst   in  synchronous, active-high reset
//     bus   slave modport of ssds_scan_driver_if
//             in : ctrl_en, ctrl_digit_0..3, ctrl_dots
//             out: seg_out, dot_out, dig_sel, frame_tick (all registered)
//
//   Parameters
//     SLOT_CYCLES    clocks per digit slot, must exceed BLANK_CYCLES
//     BLANK_CYCLES   dark clocks at the start of each slot, >= 1
//     SEG_ACTIVE_LOW 1: segment/dot pins are low to light
//     DIG_ACTIVE_LOW 1: digit commons are low to select
// ---------------------------------------------------------------------------
module ssds_scan_driver #(
  parameter int unsigned SLOT_CYCLES    = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  ssds_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  // Counter values at which the FSM changes phase.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // Logical (1 = lit / selected) to pin-level conversion.
  function automatic logic [6:0] seg_pins(input logic [6:0] lit);
    seg_pins = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
  endfunction

  function automatic logic dot_pin(input logic lit);
    dot_pin = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
  endfunction

  function automatic logic [3:0] dig_pins(input logic [3:0] sel);
    dig_pins = (DIG_ACTIVE_LOW != 0) ? ~sel : sel;
  endfunction

  // Scan state
  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       shadow_seg_q, shadow_seg_d;
  logic             shadow_dot_q, shadow_dot_d;

  // Registered pin outputs
  logic [6:0]       seg_q, seg_d;
  logic             dot_q, dot_d;
  logic [3:0]       dig_q, dig_d;
  logic             tick_q, tick_d;

  // Current digit's live inputs, selected by the scan index
  logic [6:0]       sel_seg;
  logic             sel_dot;

  // Select the live pattern and dot for the digit currently being scanned.
  always_comb begin
    sel_seg = 7'h00;
    sel_dot = bus.ctrl_dots[idx_q];
    case (idx_q)
      2'd0:    sel_seg = bus.ctrl_digit_0;
      2'd1:    sel_seg = bus.ctrl_digit_1;
      2'd2:    sel_seg = bus.ctrl_digit_2;
      2'd3:    sel_seg = bus.ctrl_digit_3;
      default: sel_seg = bus.ctrl_digit_0;
    endcase
  end

  // Next-state and next-output logic of the blank/drive scan FSM.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_seg_d = shadow_seg_q;
    shadow_dot_d = shadow_dot_q;
    seg_d        = seg_pins(7'h00);
    dot_d        = dot_pin(1'b0);
    dig_d        = dig_pins(4'h0);
    tick_d       = 1'b0;

    if (!bus.ctrl_en) begin
      // Disabled: park at the start of digit 0's blank phase, pins dark.
      state_d = ST_BLANK;
      idx_d   = 2'd0;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BLANK_LAST) begin
            // End of the gap: freeze this digit's pattern for the whole drive phase.
            state_d      = ST_DRIVE;
            shadow_seg_d = sel_seg;
            shadow_dot_d = sel_dot;
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = idx_q + 2'd1;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_BLANK;
          idx_d   = 2'd0;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase

      // Pins follow the next state so they line up with it after the clock edge.
      if (state_d == ST_DRIVE) begin
        seg_d = seg_pins(shadow_seg_d);
        dot_d = dot_pin(shadow_dot_d);
        dig_d = dig_pins(4'b0001 << idx_d);
      end else begin
        seg_d = seg_pins(7'h00);
        dot_d = dot_pin(1'b0);
        dig_d = dig_pins(4'h0);
      end

      // Frame marker: first drive cycle of digit 0 only.
      if ((state_q == ST_BLANK) && (state_d == ST_DRIVE) && (idx_q == 2'd0)) begin
        tick_d = 1'b1;
      end else begin
        tick_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= 2'd0;
      cnt_q        <= {CNT_W{1'b0}};
      shadow_seg_q <= 7'h00;
      shadow_dot_q <= 1'b0;
      seg_q        <= seg_pins(7'h00);
      dot_q        <= dot_pin(1'b0);
      dig_q        <= dig_pins(4'h0);
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_seg_q <= shadow_seg_d;
      shadow_dot_q <= shadow_dot_d;
      seg_q        <= seg_d;
      dot_q        <= dot_d;
      dig_q        <= dig_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dot_out    = dot_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_ssds_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssds_scan_driver
//   Self-checking bench for ssds_scan_driver with SLOT_CYCLES=8,
//   BLANK_CYCLES=2, active-low segments and digits. A frame-position model
//   (enabled cycles since restart, modulo the frame length) predicts every
//   output cycle; directed sequences add hand-derived constants.
// ---------------------------------------------------------------------------
module tb_ssds_scan_driver;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ssds_scan_driver_if bus_if ();

  ssds_scan_driver #(
    .SLOT_CYCLES   (SLOT),
    .BLANK_CYCLES  (BLANK),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: position within the frame and the captured pattern.
  int         m_p;
  logic [6:0] m_seg;
  logic       m_dot;
  logic [6:0] exp_seg;
  logic       exp_dot;
  logic [3:0] exp_dig;
  logic       exp_tick;

  typedef struct {
    logic [6:0] din;
    logic [6:0] seg;
    logic       dot;
    logic [3:0] dig;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_in(input int s);
    case (s)
      0:       return bus_if.ctrl_digit_0;
      1:       return bus_if.ctrl_digit_1;
      2:       return bus_if.ctrl_digit_2;
      default: return bus_if.ctrl_digit_3;
    endcase
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all four outputs with the model's prediction.
  task automatic step();
    logic       lit;
    int         slot;
    logic [3:0] one;
    one = 4'b0001;
    @(posedge clk);
    #1;
    if (rst) begin
      m_p   = 0;
      m_seg = 7'h00;
      m_dot = 1'b0;
    end else if (!bus_if.ctrl_en) begin
      m_p = 0;
    end else begin
      m_p = (m_p + 1) % FRAME;
      if (m_p % SLOT == BLANK) begin
        m_seg = digit_in(m_p / SLOT);
        m_dot = bus_if.ctrl_dots[m_p / SLOT];
      end
    end
    slot     = m_p / SLOT;
    lit      = ((m_p % SLOT) >= BLANK);
    exp_seg  = lit ? ~m_seg : 7'h7F;
    exp_dot  = lit ? ~m_dot : 1'b1;
    exp_dig  = lit ? ~(one << slot) : 4'hF;
    exp_tick = (m_p == BLANK);
    check("mdl_seg",  32'(bus_if.seg_out),    32'(exp_seg));
    check("mdl_dot",  32'(bus_if.dot_out),    32'(exp_dot));
    check("mdl_dig",  32'(bus_if.dig_sel),    32'(exp_dig));
    check("mdl_tick", 32'(bus_if.frame_tick), 32'(exp_tick));
  endtask

  task automatic expect_dark(input string name);
    check({name, "_seg"},  32'(bus_if.seg_out),    32'h7F);
    check({name, "_dot"},  32'(bus_if.dot_out),    32'h1);
    check({name, "_dig"},  32'(bus_if.dig_sel),    32'hF);
  endtask

  initial begin
    int ticks;
    int off;
    int slot;

    tbl[0] = '{din: 7'h3F, seg: 7'h40, dot: 1'b1, dig: 4'hE};
    tbl[1] = '{din: 7'h06, seg: 7'h79, dot: 1'b1, dig: 4'hD};
    tbl[2] = '{din: 7'h5B, seg: 7'h24, dot: 1'b0, dig: 4'hB};
    tbl[3] = '{din: 7'h4F, seg: 7'h30, dot: 1'b1, dig: 4'h7};

    m_p   = 0;
    m_seg = 7'h00;
    m_dot = 1'b0;

    // 1: reset for one cycle, released with the display disabled.
    rst                 = 1'b1;
    bus_if.ctrl_en      = 1'b0;
    bus_if.ctrl_digit_0 = 7'h00;
    bus_if.ctrl_digit_1 = 7'h00;
    bus_if.ctrl_digit_2 = 7'h00;
    bus_if.ctrl_digit_3 = 7'h00;
    bus_if.ctrl_dots    = 4'h0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      expect_dark("rst_idle");
      check("rst_idle_tick", 32'(bus_if.frame_tick), 32'h0);
    end

    // 2: two full frames of the table pattern.
    bus_if.ctrl_digit_0 = tbl[0].din;
    bus_if.ctrl_digit_1 = tbl[1].din;
    bus_if.ctrl_digit_2 = tbl[2].din;
    bus_if.ctrl_digit_3 = tbl[3].din;
    bus_if.ctrl_dots    = 4'b0100;
    bus_if.ctrl_en      = 1'b1;
    ticks = 0;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      step();
      off  = c % SLOT;
      slot = (c / SLOT) % 4;
      if (bus_if.frame_tick === 1'b1) ticks++;
      if (off >= BLANK) begin
        check("tbl_seg", 32'(bus_if.seg_out), 32'(tbl[slot].seg));
        check("tbl_dot", 32'(bus_if.dot_out), 32'(tbl[slot].dot));
        check("tbl_dig", 32'(bus_if.dig_sel), 32'(tbl[slot].dig));
      end else begin
        expect_dark("tbl_gap");
      end
    end
    check("tick_count", 32'(ticks), 32'd2);

    // 3: write digit 0 while it is lit; the lit value must not tear.
    for (int c = 1; c <= 34; c++) begin
      step();
      if (c == 4) bus_if.ctrl_digit_0 = 7'h7F;
      if (c >= 5 && c <= 7) check("hold_seg", 32'(bus_if.seg_out), 32'h40);
      if (c == 34) begin
        check("newframe_seg", 32'(bus_if.seg_out), 32'h00);
        check("newframe_dig", 32'(bus_if.dig_sel), 32'hE);
      end
    end

    // 4: drop enable during digit 2 drive, raise it 5 cycles later.
    for (int c = 0; c < 18; c++) step();
    check("pre_drop_dig", 32'(bus_if.dig_sel), 32'hB);
    bus_if.ctrl_en = 1'b0;
    step();
    expect_dark("drop");
    check("drop_tick", 32'(bus_if.frame_tick), 32'h0);
    for (int c = 0; c < 4; c++) step();
    bus_if.ctrl_en = 1'b1;
    step();
    expect_dark("restart_gap");
    step();
    check("restart_dig",  32'(bus_if.dig_sel),    32'hE);
    check("restart_seg",  32'(bus_if.seg_out),    32'h00);
    check("restart_tick", 32'(bus_if.frame_tick), 32'h1);

    // 5: reset in the middle of digit 3 drive.
    for (int c = 0; c < 26; c++) step();
    check("pre_rst_dig", 32'(bus_if.dig_sel), 32'h7);
    rst = 1'b1;
    step();
    expect_dark("mid_rst");
    check("mid_rst_tick", 32'(bus_if.frame_tick), 32'h0);
    rst = 1'b0;
    step();
    expect_dark("post_rst_gap");
    step();
    check("post_rst_dig",  32'(bus_if.dig_sel),    32'hE);
    check("post_rst_tick", 32'(bus_if.frame_tick), 32'h1);

    // 6: random inputs, enable and occasional reset; model plus invariants.
    for (int c = 0; c < 1000; c++) begin
      bus_if.ctrl_digit_0 = 7'($urandom);
      bus_if.ctrl_digit_1 = 7'($urandom);
      bus_if.ctrl_digit_2 = 7'($urandom);
      bus_if.ctrl_digit_3 = 7'($urandom);
      bus_if.ctrl_dots    = 4'($urandom);
      bus_if.ctrl_en      = ($urandom_range(0, 39) != 0);
      rst                 = ($urandom_range(0, 199) == 0);
      step();
      check("onehot0", 32'($countones(~bus_if.dig_sel) <= 1), 32'h1);
      check("dark_when_unselected",
            32'((bus_if.dig_sel != 4'hF) || (bus_if.seg_out == 7'h7F && bus_if.dot_out == 1'b1)),
            32'h1);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
